// File: rtl/clock_step_controller_if.sv
// Board-side signals of the execution controller: raw keys, rate/halt inputs, and core enable/status.
// core_clock_enable is a one-cycle advance strobe; there is no valid/ready handshake on this bus.
interface clock_step_controller_if;
  logic        key_step_n;
  logic        key_mode_n;
  logic [3:0]  div_sel;
  logic        core_halt;
  logic        core_clock_enable;
  logic        run_mode;
  logic [31:0] cycle_count;
  logic [1:0]  dbg_state;

  modport master (
    output key_step_n, key_mode_n, div_sel, core_halt,
    input  core_clock_enable, run_mode, cycle_count, dbg_state
  );

  modport slave (
    input  key_step_n, key_mode_n, div_sel, core_halt,
    output core_clock_enable, run_mode, cycle_count, dbg_state
  );
endinterface

// File: rtl/clock_step_controller.sv
// Debounces the step/mode keys and issues one-cycle core advance pulses in STEP or RUN mode,
// counting every pulse issued. The core stays on `clock` and qualifies updates with the pulse.
module clock_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned RESET_HOLD_CYCLES = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  clock_step_controller_if.slave bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Index 0 is the step key, index 1 the mode key.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            level_q, level_d, level_dly_q;
  logic [1:0]            press_q;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  state_t                state_q;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [14:0]           div_cnt_q;
  logic [3:0]            sel_q;
  logic [14:0]           period_m1;
  logic                  en_q, en_d;
  logic                  run_q;
  logic [31:0]           cycle_count_q, cycle_count_d;

  logic step_press, mode_press, leave_run;

  assign step_press = press_q[0];
  assign mode_press = press_q[1];
  assign leave_run  = mode_press | bus.core_halt;
  assign period_m1  = 15'((16'd1 << sel_q) - 16'd1);

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) level_d[k] = sync2_q[k];
        else db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      level_q     <= '1;
      level_dly_q <= '1;
      press_q     <= '0;
      db_cnt_q    <= '0;
    end else begin
      sync1_q     <= {bus.key_mode_n, bus.key_step_n};
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_dly_q & ~level_q;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // The pulse is suppressed in the cycle RUN is left, so halt wins over a coincident wrap.
  always_comb begin
    en_d = 1'b0;
    if (state_q == ST_STEP && step_press) en_d = 1'b1;
    if (state_q == ST_RUN && !leave_run && div_cnt_q == period_m1) en_d = 1'b1;
    cycle_count_d = cycle_count_q + 32'(en_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      sel_q      <= '0;
      en_q       <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      en_q <= en_d;
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_q <= ST_STEP;
          else hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
        ST_STEP: begin
          if (mode_press && !bus.core_halt) begin
            state_q   <= ST_RUN;
            run_q     <= 1'b1;
            div_cnt_q <= '0;
            sel_q     <= bus.div_sel;
          end
        end
        ST_RUN: begin
          if (leave_run) begin
            state_q <= ST_STEP;
            run_q   <= 1'b0;
          end else if (div_cnt_q == period_m1) begin
            div_cnt_q <= '0;
            sel_q     <= bus.div_sel;
          end else begin
            div_cnt_q <= div_cnt_q + 15'd1;
          end
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cycle_count_q <= '0;
    else          cycle_count_q <= cycle_count_d;
  end

  assign bus.core_clock_enable = en_q;
  assign bus.run_mode          = run_q;
  assign bus.cycle_count       = cycle_count_q;
  assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Bench for clock_step_controller: directed scenarios plus random key/halt/rate traffic,
// every cycle compared against a timing-level behavioural model.
module tb_clock_step_controller;

  localparam int D = 4;
  localparam int H = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  clock_step_controller_if bus();

  clock_step_controller #(
    .DEBOUNCE_CYCLES  (D),
    .RESET_HOLD_CYCLES(H)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key path: the debouncer sees each raw sample two edges late; a level flips after D
  // consecutive disagreeing samples; a fall is reported one edge later and acted on the next.
  bit          m_s1[2], m_s2[2], m_lvl[2], m_lvl_dly[2], m_press[2];
  int          m_diff[2];
  int          m_hold_left, m_age, m_per;
  bit          m_run, m_en;
  logic [31:0] m_count;
  bit          raw[2];
  bit          seen, ps, pm, en_new;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1; m_s2[k] = 1; m_lvl[k] = 1; m_lvl_dly[k] = 1;
        m_press[k] = 0; m_diff[k] = 0;
      end
      m_hold_left = H; m_run = 0; m_en = 0; m_count = 0; m_age = 0; m_per = 1;
    end else begin
      ps = m_press[0];
      pm = m_press[1];
      raw[0] = bus.key_step_n;
      raw[1] = bus.key_mode_n;
      for (int k = 0; k < 2; k++) begin
        seen         = m_s2[k];
        m_s2[k]      = m_s1[k];
        m_s1[k]      = raw[k];
        m_press[k]   = m_lvl_dly[k] && !m_lvl[k];
        m_lvl_dly[k] = m_lvl[k];
        if (seen != m_lvl[k]) m_diff[k]++;
        else m_diff[k] = 0;
        if (m_diff[k] == D) begin
          m_lvl[k]  = seen;
          m_diff[k] = 0;
        end
      end
      en_new = 0;
      if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (!m_run) begin
        if (ps) en_new = 1;
        if (pm && !bus.core_halt) begin
          m_run = 1; m_age = 0; m_per = 1 << bus.div_sel;
        end
      end else begin
        if (pm || bus.core_halt) m_run = 0;
        else if (m_age == m_per - 1) begin
          en_new = 1; m_age = 0; m_per = 1 << bus.div_sel;
        end else m_age++;
      end
      m_en = en_new;
      if (en_new) m_count = m_count + 32'd1;
    end
  end

  always @(negedge clock) begin
    check("enable", {31'd0, bus.core_clock_enable}, {31'd0, m_en});
    check("run_mode", {31'd0, bus.run_mode}, {31'd0, m_run});
    check("cycle_count", bus.cycle_count, m_count);
  end

  // ---------------- event trackers ----------------
  int cyc = 0;
  int en_seen = 0;
  int last_en_cyc = 0;
  always @(posedge clock) cyc++;
  always @(negedge clock) if (bus.core_clock_enable) begin
    en_seen++;
    last_en_cyc = cyc;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(H + 4);
  endtask

  task automatic press(input int k, input int hold);
    if (k == 0) bus.key_step_n = 1'b0; else bus.key_mode_n = 1'b0;
    step(hold);
    if (k == 0) bus.key_step_n = 1'b1; else bus.key_mode_n = 1'b1;
    step(D + 4);
  endtask

  task automatic wait_en(input string tag, output int at);
    int start;
    start = en_seen;
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (en_seen != start) begin
        at = last_en_cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no enable within 100 cycles", tag);
    end
  endtask

  // ---------------- stimulus ----------------
  int base, t0, at, prev, r, h;

  initial begin
    bus.key_step_n = 1'b1;
    bus.key_mode_n = 1'b1;
    bus.div_sel    = 4'd0;
    bus.core_halt  = 1'b0;

    // Reset and HOLD: a press during HOLD is discarded.
    step(3);
    check("reset_enable", {31'd0, bus.core_clock_enable}, 32'd0);
    check("reset_run_mode", {31'd0, bus.run_mode}, 32'd0);
    check("reset_count", bus.cycle_count, 32'd0);
    reset_n = 1'b1;
    base = en_seen;
    step(2);
    bus.key_step_n = 1'b0;
    step(10);
    bus.key_step_n = 1'b1;
    step(12);
    check("hold_no_enable", en_seen - base, 32'd0);
    check("hold_count", bus.cycle_count, 32'd0);
    press(0, 8);
    check("step_one_enable", en_seen - base, 32'd1);
    check("step_count", bus.cycle_count, 32'd1);

    // Debounce: short glitch ignored, long hold gives one pulse after 3+D cycles.
    base = en_seen;
    bus.key_step_n = 1'b0;
    step(3);
    bus.key_step_n = 1'b1;
    step(12);
    check("glitch_no_enable", en_seen - base, 32'd0);
    base = en_seen;
    t0 = cyc + 1;
    bus.key_step_n = 1'b0;
    step(200);
    bus.key_step_n = 1'b1;
    step(12);
    check("held_one_enable", en_seen - base, 32'd1);
    check("held_latency", last_en_cyc - t0, 32'(3 + D));

    // Run rate: period 8, first pulse one full period after entry.
    do_reset();
    bus.div_sel = 4'd3;
    t0 = cyc + 1;
    bus.key_mode_n = 1'b0;
    step(8);
    check("run_mode_on", {31'd0, bus.run_mode}, 32'd1);
    bus.key_mode_n = 1'b1;
    wait_en("run_first", at);
    check("run_first_pulse", at - t0, 32'(3 + D + 8));
    for (int i = 0; i < 9; i++) begin
      prev = at;
      wait_en("run_next", at);
      check("run_period_8", at - prev, 32'd8);
    end
    check("run_count_10", bus.cycle_count, 32'd10);
    bus.div_sel = 4'd0;
    prev = at;
    wait_en("sel_wrap", at);
    check("sel_change_at_wrap", at - prev, 32'd8);
    for (int i = 0; i < 4; i++) begin
      prev = at;
      wait_en("run_every", at);
      check("run_period_1", at - prev, 32'd1);
    end

    // Halt: leaves RUN next cycle, and blocks a later mode press.
    bus.div_sel = 4'd2;
    wait_en("halt_pre", at);
    wait_en("halt_pre", at);
    prev = at;
    wait_en("halt_pre", at);
    check("run_period_4", at - prev, 32'd4);
    step(1);
    bus.core_halt = 1'b1;
    step(1);
    check("halt_run_mode", {31'd0, bus.run_mode}, 32'd0);
    base = en_seen;
    step(20);
    check("halt_no_enables", en_seen - base, 32'd0);
    press(1, 8);
    check("halt_mode_stays_step", {31'd0, bus.run_mode}, 32'd0);
    check("halt_mode_no_enable", en_seen - base, 32'd0);
    bus.core_halt = 1'b0;

    // Mid-run asynchronous reset, then HOLD and STEP again.
    bus.div_sel = 4'd3;
    press(1, 8);
    check("rerun_mode_on", {31'd0, bus.run_mode}, 32'd1);
    wait_en("pre_reset", at);
    reset_n = 1'b0;
    #1;
    check("async_reset_enable", {31'd0, bus.core_clock_enable}, 32'd0);
    check("async_reset_run_mode", {31'd0, bus.run_mode}, 32'd0);
    check("async_reset_count", bus.cycle_count, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(H + 4);
    base = en_seen;
    press(0, 8);
    check("post_reset_step", en_seen - base, 32'd1);
    check("post_reset_count", bus.cycle_count, 32'd1);

    // Counter wrap.
    step(1);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    step(1);
    release dut.cycle_count_q;
    step(1);
    check("wrap_preset", bus.cycle_count, 32'hFFFF_FFFF);
    press(0, 8);
    check("wrap_to_zero", bus.cycle_count, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      h = $urandom_range(1, 10);
      if (r < 7) begin
        bus.key_step_n = 1'b0;
        step(h);
        bus.key_step_n = 1'b1;
        step($urandom_range(0, 8));
      end else if (r < 11) begin
        bus.key_mode_n = 1'b0;
        step(h);
        bus.key_mode_n = 1'b1;
        step($urandom_range(0, 8));
      end else if (r < 13) begin
        bus.core_halt = ($urandom_range(0, 3) == 0);
        step(1);
      end else if (r < 15) begin
        bus.div_sel = 4'($urandom_range(0, 3));
        step(1);
      end else if (r == 15) begin
        do_reset();
      end else begin
        step($urandom_range(1, 20));
      end
    end
    bus.core_halt = 1'b0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
